// File: rtl/ff_fifo_1r_1w.sv
// ---------------------------------------------------------------------------
// ff_fifo_1r_1w
//   Synchronous flip-flop FIFO with one write port and one read port.
//   Words leave in arrival order. A pop is a zero-latency gated read: data_o
//   shows the head entry in the same cycle the pop is accepted and is all
//   zeros otherwise. A word pushed at one edge is readable from the next
//   cycle. There is no write-to-read bypass while the FIFO is empty.
//
// Optional feature (compile-time macro FF_FIFO_ERR_EN):
//   defined   -> sticky ovf_o (dropped push) and udf_o (read while empty)
//   undefined -> ovf_o/udf_o tied to 0 and no error logic is built
//
// Parameters
//   DATA_WIDTH  width of each stored word
//   DEPTH       number of entries, power of two, >= 2
//   AW          pointer width, derived from DEPTH (do not override)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   write_en_i  push data_i this cycle
//   data_i      write data
//   read_en_i   pop the head entry this cycle
//   data_o      head entry while a pop is accepted, else all zeros
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
//   count_o     number of valid entries, 0..DEPTH
//   ovf_o       sticky overflow flag
//   udf_o       sticky underflow flag
// ---------------------------------------------------------------------------
module ff_fifo_1r_1w #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  read_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           count_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  pop_acc;
  logic                  push_acc;

  // Status comes from the count register only, never from the enables.
  assign full_o  = (count == FULL_COUNT);
  assign empty_o = (count == '0);
  assign count_o = count;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it is paired with a pop.
  assign pop_acc  = read_en_i && !empty_o;
  assign push_acc = write_en_i && (!full_o || pop_acc);

  // Gated read: zeros unless a pop is accepted this cycle.
  always_comb begin
    // NOTE: assign a default before any condition in always_comb so no path
    // leaves the output unassigned, which would infer a latch.
    data_o = '0;
    if (pop_acc) begin
      data_o = mem[rd_ptr];
    end
  end

  // NOTE: entry storage has no reset. Nothing can read it while the FIFO is
  // empty, so clearing it would only add reset fan-out to every storage flop.
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FF_FIFO_ERR_EN
  // Sticky error flags. They are cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (write_en_i && full_o && !pop_acc) begin
        ovf_o <= 1'b1;
      end
      if (read_en_i && empty_o) begin
        udf_o <= 1'b1;
      end
    end
  end
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_ff_fifo_1r_1w.sv
// ---------------------------------------------------------------------------
// tb_ff_fifo_1r_1w
//   Self-checking bench for ff_fifo_1r_1w (DATA_WIDTH=32, DEPTH=4).
//   A queue-based reference model predicts data_o, count and status for
//   every driven cycle. Inputs change on the falling edge, and outputs are
//   sampled 1 ns later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_ff_fifo_1r_1w;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en_i;
  logic [DW-1:0] data_i;
  logic          read_en_i;
  logic [DW-1:0] data_o;
  logic          full_o;
  logic          empty_o;
  logic [AW:0]   count_o;
  logic          ovf_o;
  logic          udf_o;

  ff_fifo_1r_1w #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_en_i (write_en_i),
    .data_i     (data_i),
    .read_en_i  (read_en_i),
    .data_o     (data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o),
    .udf_o      (udf_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] model_q[$];
  logic          model_ovf;
  logic          model_udf;

  // Per-cycle observed and expected vectors:
  // {data, count, full, empty, ovf, udf}
  localparam int VW = DW + AW + 1 + 4;
  logic [VW-1:0] obs;
  logic [VW-1:0] exp_v;

  int checks = 0;
  int errors = 0;

  // Apply one cycle of stimulus, capture the observed and expected outputs,
  // and then advance DUT and model across the rising edge.
  task automatic drive(input logic we, input logic [DW-1:0] d, input logic re);
    logic [DW-1:0] e_data;
    logic          pop;
    logic          push;
    @(negedge clk);
    write_en_i = we;
    data_i     = d;
    read_en_i  = re;
    #1;
    e_data = (re && model_q.size() > 0) ? model_q[0] : '0;
    exp_v  = {e_data, (AW+1)'(model_q.size()),
              model_q.size() == DEPTH, model_q.size() == 0,
`ifdef FF_FIFO_ERR_EN
              model_ovf, model_udf};
`else
              1'b0, 1'b0};
`endif
    obs    = {data_o, count_o, full_o, empty_o, ovf_o, udf_o};
    @(posedge clk);
    pop  = re && model_q.size() > 0;
    push = we && (model_q.size() < DEPTH || pop);
    if (we && model_q.size() == DEPTH && !pop) model_ovf = 1'b1;
    if (re && model_q.size() == 0) model_udf = 1'b1;
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back(d);
  endtask

  // Reset asserted for one edge with both enables high, so any push or pop
  // in that cycle must be ignored.
  task automatic apply_reset();
    @(negedge clk);
    rst        = 1'b1;
    write_en_i = 1'b1;
    read_en_i  = 1'b1;
    data_i     = 32'hDEAD_BEEF;
    @(posedge clk);
    model_q.delete();
    model_ovf = 1'b0;
    model_udf = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    apply_reset();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hA0 + DW'(i), 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL fill push%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL drain pop%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h1, 1'b0);
    drive(1'b1, 32'h2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hB0 + DW'(i), 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b_drain%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    apply_reset();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h50 + DW'(i), 1'b0);
    drive(1'b1, 32'hC0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL full_pushpop got=%h exp=%h", obs, exp_v);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL full_drain%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    apply_reset();
  endtask

  task automatic test_empty_push_pop();
    drive(1'b1, 32'hD0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL empty_pushpop got=%h exp=%h", obs, exp_v);
    end
    drive(1'b0, '0, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL empty_follow got=%h exp=%h", obs, exp_v);
    end
    apply_reset();
  endtask

  task automatic test_errors_and_mid_reset();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'hE0 + DW'(i), 1'b0);
    drive(1'b1, 32'hEF, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL sticky_flags got=%h exp=%h", obs, exp_v);
    end
    apply_reset();
    drive(1'b0, '0, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
    apply_reset();
  endtask

  initial begin
    rst        = 1'b1;
    write_en_i = 1'b0;
    read_en_i  = 1'b0;
    data_i     = '0;
    model_ovf  = 1'b0;
    model_udf  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_push_pop();
    test_empty_push_pop();
    test_errors_and_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
